// File: rtl/reg_file_pkg.sv
// Shared constants and types for the register-file operand fetch path.
//   NUM_REGS / ADDR_W / DATA_W : architectural register-file geometry
//   fetch_state_e              : operand fetch sequencer states
//   operand_req_t              : latched decode request payload
package reg_file_pkg;

    localparam int unsigned NUM_REGS = 32;
    localparam int unsigned ADDR_W   = 5;
    localparam int unsigned DATA_W   = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        READ  = 2'd2,
        RESP  = 2'd3
    } fetch_state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] rs1;
        logic [ADDR_W-1:0] rs2;
        logic              use_rs1;
        logic              use_rs2;
        logic [ADDR_W-1:0] rd;
        logic              rd_wr;
    } operand_req_t;

    // A read port is only exercised for a used, non-zero source register.
    function automatic logic port_needed(input logic use_f, input logic [ADDR_W-1:0] addr);
        return use_f && (addr != ADDR_W'(0));
    endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-writeback scoreboard, one busy bit per architectural register.
//   clk, reset            : clock, synchronous active-high reset
//   i_set_en / i_set_idx  : mark a register as having an outstanding write
//   i_clr_en / i_clr_idx  : retire an outstanding write
//   i_lookup*_idx         : registers to test for a RAW hazard
//   o_lookup*_busy_c      : combinational busy bit of each looked-up register
//   o_busy                : registered busy vector (bit 0 always 0)
module reg_scoreboard #(
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned ADDR_W   = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_set_en,
    input  logic [ADDR_W-1:0]   i_set_idx,
    input  logic                i_clr_en,
    input  logic [ADDR_W-1:0]   i_clr_idx,
    input  logic [ADDR_W-1:0]   i_lookup1_idx,
    input  logic [ADDR_W-1:0]   i_lookup2_idx,
    output logic                o_lookup1_busy_c,
    output logic                o_lookup2_busy_c,
    output logic [NUM_REGS-1:0] o_busy
);

    logic [NUM_REGS-1:0] r_busy;
    logic [NUM_REGS-1:0] w_busy_nxt;

    // Clear first, then set, so a newly issued writer wins over a retiring one.
    always_comb begin
        w_busy_nxt = r_busy;
        if (i_clr_en) begin
            w_busy_nxt[i_clr_idx] = 1'b0;
        end
        if (i_set_en) begin
            w_busy_nxt[i_set_idx] = 1'b1;
        end
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    assign o_lookup1_busy_c = r_busy[i_lookup1_idx];
    assign o_lookup2_busy_c = r_busy[i_lookup2_idx];
    assign o_busy           = r_busy;

endmodule

// File: rtl/reg_operand_fetch.sv
// Operand fetch sequencer between decode and the register file.
// Accepts one instruction at a time, stalls while a source has a pending
// writeback, reads rs1 on port A and rs2 on port B, then presents operands.
//   clk, reset                      : clock, synchronous active-high reset
//   req_*                           : decode request (valid/ready handshake)
//   rsp_*                           : operand response (valid/ready handshake)
//   reg_rd_addr_{a,b}[_valid]       : register-file read requests
//   reg_rd_data_{a,b}[_ack]         : register-file read returns
//   reg_wr_addr/data_valid/ack      : monitored write port, retires scoreboard
//   sb_busy                         : pending-write vector
module reg_operand_fetch
    import reg_file_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [ADDR_W-1:0]   req_rs1,
    input  logic [ADDR_W-1:0]   req_rs2,
    input  logic                req_use_rs1,
    input  logic                req_use_rs2,
    input  logic [ADDR_W-1:0]   req_rd,
    input  logic                req_rd_wr,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_rs1_data,
    output logic [DATA_W-1:0]   rsp_rs2_data,
    output logic [ADDR_W-1:0]   reg_rd_addr_a,
    output logic                reg_rd_addr_a_valid,
    input  logic [DATA_W-1:0]   reg_rd_data_a,
    input  logic                reg_rd_data_a_ack,
    output logic [ADDR_W-1:0]   reg_rd_addr_b,
    output logic                reg_rd_addr_b_valid,
    input  logic [DATA_W-1:0]   reg_rd_data_b,
    input  logic                reg_rd_data_b_ack,
    input  logic [ADDR_W-1:0]   reg_wr_addr,
    input  logic                reg_wr_data_valid,
    input  logic                reg_wr_ack,
    output logic [NUM_REGS-1:0] sb_busy
);

    fetch_state_e r_state;
    fetch_state_e w_state_nxt;

    operand_req_t      r_req;
    operand_req_t      w_req_nxt;
    logic [ADDR_W-1:0] r_a_addr, w_a_addr_nxt;
    logic [ADDR_W-1:0] r_b_addr, w_b_addr_nxt;
    logic              r_a_valid, w_a_valid_nxt;
    logic              r_b_valid, w_b_valid_nxt;
    logic [DATA_W-1:0] r_a_data, w_a_data_nxt;
    logic [DATA_W-1:0] r_b_data, w_b_data_nxt;
    logic              r_rsp_valid, w_rsp_valid_nxt;

    logic w_need_a;
    logic w_need_b;
    logic w_rs1_busy;
    logic w_rs2_busy;
    logic w_hazard;
    logic w_sb_set;
    logic w_sb_clr;

    reg_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W)
    ) u_scoreboard (
        .clk              (clk),
        .reset            (reset),
        .i_set_en         (w_sb_set),
        .i_set_idx        (r_req.rd),
        .i_clr_en         (w_sb_clr),
        .i_clr_idx        (reg_wr_addr),
        .i_lookup1_idx    (r_req.rs1),
        .i_lookup2_idx    (r_req.rs2),
        .o_lookup1_busy_c (w_rs1_busy),
        .o_lookup2_busy_c (w_rs2_busy),
        .o_busy           (sb_busy)
    );

    assign w_need_a = port_needed(r_req.use_rs1, r_req.rs1);
    assign w_need_b = port_needed(r_req.use_rs2, r_req.rs2);
    assign w_hazard = (w_need_a && w_rs1_busy) || (w_need_b && w_rs2_busy);
    assign w_sb_clr = reg_wr_data_valid && reg_wr_ack;

    // Next-state and datapath next values.
    always_comb begin
        w_state_nxt     = r_state;
        w_req_nxt       = r_req;
        w_a_addr_nxt    = r_a_addr;
        w_b_addr_nxt    = r_b_addr;
        w_a_valid_nxt   = r_a_valid;
        w_b_valid_nxt   = r_b_valid;
        w_a_data_nxt    = r_a_data;
        w_b_data_nxt    = r_b_data;
        w_rsp_valid_nxt = r_rsp_valid;
        w_sb_set        = 1'b0;

        case (r_state)
            IDLE: begin
                if (req_valid) begin
                    w_req_nxt.rs1     = req_rs1;
                    w_req_nxt.rs2     = req_rs2;
                    w_req_nxt.use_rs1 = req_use_rs1;
                    w_req_nxt.use_rs2 = req_use_rs2;
                    w_req_nxt.rd      = req_rd;
                    w_req_nxt.rd_wr   = req_rd_wr;
                    w_state_nxt       = CHECK;
                end
            end

            CHECK: begin
                if (!w_hazard) begin
                    // Unneeded ports must report zero, so clear both up front.
                    w_a_data_nxt = '0;
                    w_b_data_nxt = '0;
                    if (w_need_a || w_need_b) begin
                        w_a_valid_nxt = w_need_a;
                        w_b_valid_nxt = w_need_b;
                        w_a_addr_nxt  = w_need_a ? r_req.rs1 : ADDR_W'(0);
                        w_b_addr_nxt  = w_need_b ? r_req.rs2 : ADDR_W'(0);
                        w_state_nxt   = READ;
                    end else begin
                        w_rsp_valid_nxt = 1'b1;
                        w_state_nxt     = RESP;
                    end
                end
            end

            READ: begin
                // Acks only count while the matching request is outstanding.
                if (r_a_valid && reg_rd_data_a_ack) begin
                    w_a_data_nxt  = reg_rd_data_a;
                    w_a_valid_nxt = 1'b0;
                end
                if (r_b_valid && reg_rd_data_b_ack) begin
                    w_b_data_nxt  = reg_rd_data_b;
                    w_b_valid_nxt = 1'b0;
                end
                if (!w_a_valid_nxt && !w_b_valid_nxt) begin
                    w_rsp_valid_nxt = 1'b1;
                    w_state_nxt     = RESP;
                end
            end

            RESP: begin
                if (rsp_ready) begin
                    w_rsp_valid_nxt = 1'b0;
                    w_sb_set        = r_req.rd_wr && (r_req.rd != ADDR_W'(0));
                    w_state_nxt     = IDLE;
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_req       <= '0;
            r_a_addr    <= '0;
            r_b_addr    <= '0;
            r_a_valid   <= 1'b0;
            r_b_valid   <= 1'b0;
            r_a_data    <= '0;
            r_b_data    <= '0;
            r_rsp_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_req       <= w_req_nxt;
            r_a_addr    <= w_a_addr_nxt;
            r_b_addr    <= w_b_addr_nxt;
            r_a_valid   <= w_a_valid_nxt;
            r_b_valid   <= w_b_valid_nxt;
            r_a_data    <= w_a_data_nxt;
            r_b_data    <= w_b_data_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
        end
    end

    assign req_ready           = (r_state == IDLE) && !reset;
    assign rsp_valid           = r_rsp_valid;
    assign rsp_rs1_data        = r_a_data;
    assign rsp_rs2_data        = r_b_data;
    assign reg_rd_addr_a       = r_a_addr;
    assign reg_rd_addr_a_valid = r_a_valid;
    assign reg_rd_addr_b       = r_b_addr;
    assign reg_rd_addr_b_valid = r_b_valid;

endmodule

// File: tb/tb_reg_operand_fetch.sv
// Directed bench for reg_operand_fetch: fetch, skewed acks, x0/unused,
// RAW stall, set/clear collision and mid-read reset.
module tb_reg_operand_fetch;
    import reg_file_pkg::*;

    logic                clk = 1'b0;
    logic                reset;
    logic                req_valid;
    logic                req_ready;
    logic [ADDR_W-1:0]   req_rs1, req_rs2, req_rd;
    logic                req_use_rs1, req_use_rs2, req_rd_wr;
    logic                rsp_valid, rsp_ready;
    logic [DATA_W-1:0]   rsp_rs1_data, rsp_rs2_data;
    logic [ADDR_W-1:0]   reg_rd_addr_a, reg_rd_addr_b;
    logic                reg_rd_addr_a_valid, reg_rd_addr_b_valid;
    logic [DATA_W-1:0]   reg_rd_data_a, reg_rd_data_b;
    logic                reg_rd_data_a_ack, reg_rd_data_b_ack;
    logic [ADDR_W-1:0]   reg_wr_addr;
    logic                reg_wr_data_valid, reg_wr_ack;
    logic [NUM_REGS-1:0] sb_busy;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    reg_operand_fetch dut (
        .clk                 (clk),
        .reset               (reset),
        .req_valid           (req_valid),
        .req_ready           (req_ready),
        .req_rs1             (req_rs1),
        .req_rs2             (req_rs2),
        .req_use_rs1         (req_use_rs1),
        .req_use_rs2         (req_use_rs2),
        .req_rd              (req_rd),
        .req_rd_wr           (req_rd_wr),
        .rsp_valid           (rsp_valid),
        .rsp_ready           (rsp_ready),
        .rsp_rs1_data        (rsp_rs1_data),
        .rsp_rs2_data        (rsp_rs2_data),
        .reg_rd_addr_a       (reg_rd_addr_a),
        .reg_rd_addr_a_valid (reg_rd_addr_a_valid),
        .reg_rd_data_a       (reg_rd_data_a),
        .reg_rd_data_a_ack   (reg_rd_data_a_ack),
        .reg_rd_addr_b       (reg_rd_addr_b),
        .reg_rd_addr_b_valid (reg_rd_addr_b_valid),
        .reg_rd_data_b       (reg_rd_data_b),
        .reg_rd_data_b_ack   (reg_rd_data_b_ack),
        .reg_wr_addr         (reg_wr_addr),
        .reg_wr_data_valid   (reg_wr_data_valid),
        .reg_wr_ack          (reg_wr_ack),
        .sb_busy             (sb_busy)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [ADDR_W-1:0] rs1, input logic [ADDR_W-1:0] rs2,
                         input logic u1, input logic u2,
                         input logic [ADDR_W-1:0] rd, input logic rdwr);
        req_rs1     = rs1;
        req_rs2     = rs2;
        req_use_rs1 = u1;
        req_use_rs2 = u2;
        req_rd      = rd;
        req_rd_wr   = rdwr;
        req_valid   = 1'b1;
    endtask

    initial begin
        reset = 1'b1;
        req_valid = 1'b0; req_rs1 = '0; req_rs2 = '0; req_rd = '0;
        req_use_rs1 = 1'b0; req_use_rs2 = 1'b0; req_rd_wr = 1'b0;
        rsp_ready = 1'b0;
        reg_rd_data_a = '0; reg_rd_data_b = '0;
        reg_rd_data_a_ack = 1'b0; reg_rd_data_b_ack = 1'b0;
        reg_wr_addr = '0; reg_wr_data_valid = 1'b0; reg_wr_ack = 1'b0;

        // Reset state
        step(); step();
        check("rst_ready",   64'(req_ready), 64'h0);
        check("rst_rspv",    64'(rsp_valid), 64'h0);
        check("rst_av",      64'(reg_rd_addr_a_valid), 64'h0);
        check("rst_bv",      64'(reg_rd_addr_b_valid), 64'h0);
        check("rst_busy",    64'(sb_busy), 64'h0);
        check("rst_d1",      64'(rsp_rs1_data), 64'h0);
        reset = 1'b0;
        #1;
        check("rst_ready_rel", 64'(req_ready), 64'h1);

        // Basic fetch: rs1=3, rs2=7, acks in cycle 2
        issue(5'd3, 5'd7, 1'b1, 1'b1, 5'd0, 1'b0);
        step();                                          // cycle 1 (CHECK)
        req_valid = 1'b0;
        check("t1_c1_ready", 64'(req_ready), 64'h0);
        check("t1_c1_av",    64'(reg_rd_addr_a_valid), 64'h0);
        step();                                          // cycle 2
        check("t1_c2_av",    64'(reg_rd_addr_a_valid), 64'h1);
        check("t1_c2_aa",    64'(reg_rd_addr_a), 64'd3);
        check("t1_c2_bv",    64'(reg_rd_addr_b_valid), 64'h1);
        check("t1_c2_ba",    64'(reg_rd_addr_b), 64'd7);
        reg_rd_data_a = 32'h1111_1111; reg_rd_data_a_ack = 1'b1;
        reg_rd_data_b = 32'h7777_7777; reg_rd_data_b_ack = 1'b1;
        step();                                          // cycle 3
        reg_rd_data_a_ack = 1'b0; reg_rd_data_b_ack = 1'b0;
        check("t1_c3_rspv",  64'(rsp_valid), 64'h1);
        check("t1_c3_d1",    64'(rsp_rs1_data), 64'h1111_1111);
        check("t1_c3_d2",    64'(rsp_rs2_data), 64'h7777_7777);
        check("t1_c3_av",    64'(reg_rd_addr_a_valid), 64'h0);
        check("t1_c3_bv",    64'(reg_rd_addr_b_valid), 64'h0);
        check("t1_c3_busy",  64'(sb_busy), 64'h0);
        step();                                          // rsp held without ready
        check("t1_hold_rspv", 64'(rsp_valid), 64'h1);
        check("t1_hold_d1",   64'(rsp_rs1_data), 64'h1111_1111);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check("t1_done_rspv",  64'(rsp_valid), 64'h0);
        check("t1_done_ready", 64'(req_ready), 64'h1);
        check("t1_done_busy",  64'(sb_busy), 64'h0);

        // Skewed acks: A in cycle 2, B in cycle 5
        issue(5'd3, 5'd7, 1'b1, 1'b1, 5'd0, 1'b0);
        step(); req_valid = 1'b0;                        // cycle 1
        step();                                          // cycle 2
        reg_rd_data_a = 32'hA5A5_A5A5; reg_rd_data_a_ack = 1'b1;
        step();                                          // cycle 3
        reg_rd_data_a_ack = 1'b0;
        check("t2_c3_av",  64'(reg_rd_addr_a_valid), 64'h0);
        check("t2_c3_bv",  64'(reg_rd_addr_b_valid), 64'h1);
        check("t2_c3_ba",  64'(reg_rd_addr_b), 64'd7);
        check("t2_c3_rspv", 64'(rsp_valid), 64'h0);
        // Stray ack on port A while its valid is low must be ignored
        reg_rd_data_a = 32'hDEAD_BEEF; reg_rd_data_a_ack = 1'b1;
        step();                                          // cycle 4
        reg_rd_data_a_ack = 1'b0;
        check("t2_c4_bv",  64'(reg_rd_addr_b_valid), 64'h1);
        check("t2_c4_ba",  64'(reg_rd_addr_b), 64'd7);
        step();                                          // cycle 5
        check("t2_c5_bv",  64'(reg_rd_addr_b_valid), 64'h1);
        check("t2_c5_ba",  64'(reg_rd_addr_b), 64'd7);
        check("t2_c5_rspv", 64'(rsp_valid), 64'h0);
        reg_rd_data_b = 32'h5A5A_0007; reg_rd_data_b_ack = 1'b1;
        step();                                          // cycle 6
        reg_rd_data_b_ack = 1'b0;
        check("t2_c6_rspv", 64'(rsp_valid), 64'h1);
        check("t2_c6_d1",   64'(rsp_rs1_data), 64'hA5A5_A5A5);
        check("t2_c6_d2",   64'(rsp_rs2_data), 64'h5A5A_0007);
        check("t2_c6_bv",   64'(reg_rd_addr_b_valid), 64'h0);
        rsp_ready = 1'b1; step(); rsp_ready = 1'b0;

        // x0 used, rs2=9 unused: no port traffic, zero data in cycle 2
        issue(5'd0, 5'd9, 1'b1, 1'b0, 5'd0, 1'b0);
        step(); req_valid = 1'b0;                        // cycle 1
        check("t3_c1_rspv", 64'(rsp_valid), 64'h0);
        step();                                          // cycle 2
        check("t3_c2_rspv", 64'(rsp_valid), 64'h1);
        check("t3_c2_av",   64'(reg_rd_addr_a_valid), 64'h0);
        check("t3_c2_bv",   64'(reg_rd_addr_b_valid), 64'h0);
        check("t3_c2_d1",   64'(rsp_rs1_data), 64'h0);
        check("t3_c2_d2",   64'(rsp_rs2_data), 64'h0);
        rsp_ready = 1'b1; step(); rsp_ready = 1'b0;

        // RAW stall: rd=5 writer, then reader of rs1=5
        issue(5'd0, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1);
        step(); req_valid = 1'b0;                        // cycle 1
        step();                                          // cycle 2, rsp
        check("t4_w_rspv", 64'(rsp_valid), 64'h1);
        rsp_ready = 1'b1; step(); rsp_ready = 1'b0;      // cycle 3
        check("t4_busy5",  64'(sb_busy), 64'h0000_0020);
        check("t4_ready",  64'(req_ready), 64'h1);
        issue(5'd5, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0);
        step(); req_valid = 1'b0;                        // CHECK
        step();
        check("t4_stall_av1", 64'(reg_rd_addr_a_valid), 64'h0);
        check("t4_stall_rdy", 64'(req_ready), 64'h0);
        step();
        check("t4_stall_av2", 64'(reg_rd_addr_a_valid), 64'h0);
        reg_wr_addr = 5'd5; reg_wr_data_valid = 1'b1; reg_wr_ack = 1'b1;
        step();
        reg_wr_data_valid = 1'b0; reg_wr_ack = 1'b0;
        check("t4_clr_busy", 64'(sb_busy), 64'h0);
        check("t4_clr_av",   64'(reg_rd_addr_a_valid), 64'h0);
        step();
        check("t4_issue_av", 64'(reg_rd_addr_a_valid), 64'h1);
        check("t4_issue_aa", 64'(reg_rd_addr_a), 64'd5);
        check("t4_issue_bv", 64'(reg_rd_addr_b_valid), 64'h0);
        reg_rd_data_a = 32'h0000_0055; reg_rd_data_a_ack = 1'b1;
        step();
        reg_rd_data_a_ack = 1'b0;
        check("t4_rspv", 64'(rsp_valid), 64'h1);
        check("t4_d1",   64'(rsp_rs1_data), 64'h55);
        check("t4_d2",   64'(rsp_rs2_data), 64'h0);
        rsp_ready = 1'b1; step(); rsp_ready = 1'b0;

        // Set/clear collision on rd=4: set wins
        issue(5'd0, 5'd0, 1'b0, 1'b0, 5'd4, 1'b1);
        step(); req_valid = 1'b0;
        step();                                          // rsp
        rsp_ready = 1'b1;
        reg_wr_addr = 5'd4; reg_wr_data_valid = 1'b1; reg_wr_ack = 1'b1;
        step();
        rsp_ready = 1'b0; reg_wr_data_valid = 1'b0; reg_wr_ack = 1'b0;
        check("t5_collide", 64'(sb_busy), 64'h0000_0010);
        // Valid without ack retires nothing
        reg_wr_addr = 5'd4; reg_wr_data_valid = 1'b1;
        step();
        reg_wr_data_valid = 1'b0;
        check("t5_noack", 64'(sb_busy), 64'h0000_0010);
        reg_wr_data_valid = 1'b1; reg_wr_ack = 1'b1;
        step();
        reg_wr_data_valid = 1'b0; reg_wr_ack = 1'b0;
        check("t5_retire", 64'(sb_busy), 64'h0);
        // Writer of x0 never marks busy
        issue(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1);
        step(); req_valid = 1'b0;
        step();
        rsp_ready = 1'b1; step(); rsp_ready = 1'b0;
        check("t5_x0", 64'(sb_busy), 64'h0);

        // Reset mid-READ with a pending scoreboard bit
        issue(5'd0, 5'd0, 1'b0, 1'b0, 5'd6, 1'b1);
        step(); req_valid = 1'b0;
        step();
        rsp_ready = 1'b1; step(); rsp_ready = 1'b0;
        check("t6_busy6", 64'(sb_busy), 64'h0000_0040);
        issue(5'd3, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0);
        step(); req_valid = 1'b0;                        // cycle 1
        step();                                          // cycle 2
        check("t6_av", 64'(reg_rd_addr_a_valid), 64'h1);
        step();                                          // cycle 3, still waiting
        check("t6_av_hold", 64'(reg_rd_addr_a_valid), 64'h1);
        reset = 1'b1;
        #1;
        check("t6_rst_ready", 64'(req_ready), 64'h0);
        step();
        reset = 1'b0;
        reg_rd_data_a = 32'hBAD0_BAD0; reg_rd_data_a_ack = 1'b1;
        #1;
        check("t6_av0",   64'(reg_rd_addr_a_valid), 64'h0);
        check("t6_rspv0", 64'(rsp_valid), 64'h0);
        check("t6_busy0", 64'(sb_busy), 64'h0);
        check("t6_ready", 64'(req_ready), 64'h1);
        step();
        reg_rd_data_a_ack = 1'b0;
        check("t6_late_av",   64'(reg_rd_addr_a_valid), 64'h0);
        check("t6_late_rspv", 64'(rsp_valid), 64'h0);
        check("t6_late_d1",   64'(rsp_rs1_data), 64'h0);
        check("t6_late_rdy",  64'(req_ready), 64'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
